square_pipelined: RTL and testbench

Fully pipelined unsigned integer squarer: accepts one BITS-wide operand per clock and returns its exact 2*BITS-wide square after a fixed latency. It is the inverse companion of the math library's pipelined square-root block, producing a square on the forward path that the square-root stage consumes. It uses one shift-add stage per operand bit, with a valid bit travelling alongside the data and a global clock enable for stalling.

---
 rtl/square_pipelined.sv | 53 +++++
 tb/tb_square_pipelined.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/square_pipelined.sv
// rtl/square_pipelined.sv - pipelined shift-add unsigned squarer
// One stage per operand bit; a valid bit and the operand travel with each partial sum.
module square_pipelined #(
  parameter int BITS = 32,
  parameter int UP   = BITS - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              in_valid,
  input  logic [UP:0]       x,
  output logic              out_valid,
  output logic [2*BITS-1:0] osq,
  output logic [UP:0]       otag
);

  localparam int AW = 2 * BITS;

  logic [UP:0]   r_op  [0:BITS];
  logic [AW-1:0] r_acc [0:BITS];
  logic [BITS:0] r_v;
  logic [AW-1:0] w_sum [1:BITS];

  // Stage k adds the operand shifted by k-1 when operand bit k-1 is set.
  for (genvar k = 1; k <= BITS; k++) begin : g_stage
    assign w_sum[k] = r_acc[k-1] +
                      (r_op[k-1][k-1] ? ({{BITS{1'b0}}, r_op[k-1]} << (k-1)) : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      for (int k = 0; k <= BITS; k++) begin
        r_op[k]  <= '0;
        r_acc[k] <= '0;
      end
    end else if (ce) begin
      r_op[0]  <= x;
      r_acc[0] <= '0;
      r_v[0]   <= in_valid;
      for (int k = 1; k <= BITS; k++) begin
        r_op[k]  <= r_op[k-1];
        r_acc[k] <= w_sum[k];
        r_v[k]   <= r_v[k-1];
      end
    end
  end

  assign osq       = r_acc[BITS];
  assign otag      = r_op[BITS];
  assign out_valid = r_v[BITS];

endmodule

// File: tb/tb_square_pipelined.sv
// tb/tb_square_pipelined.sv - scoreboard bench for square_pipelined at widths 32 and 8
module tb_square_pipelined;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce, in_valid;
  logic [31:0] x;
  logic        out_valid;
  logic [63:0] osq;
  logic [31:0] otag;
  logic        out_valid8;
  logic [15:0] osq8;
  logic [7:0]  otag8;

  square_pipelined #(.BITS(32)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .x(x),
    .out_valid(out_valid), .osq(osq), .otag(otag)
  );

  square_pipelined #(.BITS(8)) dut8 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .x(x[7:0]),
    .out_valid(out_valid8), .osq(osq8), .otag(otag8)
  );

  typedef struct {
    int          due;
    logic [63:0] tag;
    logic [63:0] sq;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    logic [63:0] sq;
  } vec_t;

  exp_t q32[$];
  exp_t q8[$];
  vec_t corners[6];

  int          en_count = 0;
  int          checks   = 0;
  int          errors   = 0;
  logic        ev32 = 1'b0, ev8 = 1'b0;
  logic [63:0] es32 = '0, et32 = '0, es8 = '0, et8 = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, update the expected-output model at the edge, check at the negedge.
  task automatic step(input logic c, input logic r, input logic v,
                      input logic [31:0] xv, input logic [63:0] sq);
    exp_t e;
    rst = r; ce = c; in_valid = v; x = xv;
    @(posedge clk);
    if (r) begin
      q32.delete(); q8.delete();
      ev32 = 1'b0; es32 = '0; et32 = '0;
      ev8  = 1'b0; es8  = '0; et8  = '0;
    end else if (c) begin
      en_count++;
      if (v) begin
        e.due = en_count + 32; e.tag = 64'(xv);      e.sq = sq;
        q32.push_back(e);
        e.due = en_count + 8;  e.tag = 64'(xv[7:0]); e.sq = 64'(xv[7:0]) * 64'(xv[7:0]);
        q8.push_back(e);
      end
      ev32 = 1'b0;
      if (q32.size() > 0 && q32[0].due == en_count) begin
        e = q32.pop_front(); ev32 = 1'b1; es32 = e.sq; et32 = e.tag;
      end
      ev8 = 1'b0;
      if (q8.size() > 0 && q8[0].due == en_count) begin
        e = q8.pop_front(); ev8 = 1'b1; es8 = e.sq; et8 = e.tag;
      end
    end
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(ev32));
    if (ev32 || r) begin
      chk("osq", osq, es32);
      chk("otag", 64'(otag), et32);
    end
    chk("out_valid8", 64'(out_valid8), 64'(ev8));
    if (ev8 || r) begin
      chk("osq8", 64'(osq8), es8);
      chk("otag8", 64'(otag8), et8);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] xv;
    logic        c, v;

    corners[0] = '{32'h0000_0000, 64'h0000_0000_0000_0000};
    corners[1] = '{32'h0000_0001, 64'h0000_0000_0000_0001};
    corners[2] = '{32'h0000_0002, 64'h0000_0000_0000_0004};
    corners[3] = '{32'h0000_FFFF, 64'h0000_0000_FFFE_0001};
    corners[4] = '{32'h0001_0000, 64'h0000_0001_0000_0000};
    corners[5] = '{32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};

    rst = 1'b1; ce = 1'b0; in_valid = 1'b0; x = '0;
    @(negedge clk);

    // Reset held with a valid operand presented: nothing may get through.
    repeat (3) step(1'b1, 1'b1, 1'b1, 32'd5, 64'd25);
    for (int i = 0; i < 33; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0, 64'd0);
      chk("idle_osq", osq, 64'd0);
      chk("idle_otag", 64'(otag), 64'd0);
    end

    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, corners[i].x, corners[i].sq);
    idle(40);

    // Explicit latency count from the sampling edge, inclusive.
    step(1'b1, 1'b0, 1'b1, 32'h0000_1234, 64'h1234 * 64'h1234);
    lat = 1;
    do begin
      step(1'b1, 1'b0, 1'b0, 32'd0, 64'd0);
      lat++;
    end while (!out_valid && lat < 60);
    chk("latency32", 64'(lat), 64'd33);
    idle(5);

    for (int i = 0; i < 1000; i++) begin
      xv = $urandom;
      step(1'b1, 1'b0, 1'b1, xv, 64'(xv) * 64'(xv));
    end
    idle(40);

    // Random in_valid gaps and random stalls, including stalls while results are valid.
    for (int i = 0; i < 400; i++) begin
      xv = $urandom;
      v  = ($urandom_range(0, 2) != 0);
      c  = ($urandom_range(0, 4) != 0);
      step(c, 1'b0, v, xv, 64'(xv) * 64'(xv));
    end
    idle(40);

    // Ten operands, then a 7-cycle stall at cycle 15 with junk presented.
    for (int i = 0; i < 30; i++) begin
      xv = $urandom;
      if (i < 10)
        step(1'b1, 1'b0, 1'b1, xv, 64'(xv) * 64'(xv));
      else if (i >= 15 && i < 22)
        step(1'b0, 1'b0, 1'b1, xv, 64'(xv) * 64'(xv));
      else
        step(1'b1, 1'b0, 1'b0, 32'd0, 64'd0);
    end
    idle(40);

    // Twenty operands with a one-cycle reset at cycle 12.
    for (int i = 0; i < 20; i++) begin
      xv = $urandom;
      step(1'b1, (i == 12), 1'b1, xv, 64'(xv) * 64'(xv));
    end
    idle(40);

    for (int i = 0; i < 256; i++)
      step(1'b1, 1'b0, 1'b1, 32'(i), 64'(i) * 64'(i));
    idle(40);

    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
